// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART transceiver with RX FIFO
// Optional feature macro: UART_PARITY_EN (adds a parity bit on RX and TX).
// Ports: clk/rst (async active-high); uart_rx/uart_tx serial pins (idle high);
//        tx_data/tx_valid/tx_ready byte input handshake;
//        rx_data/rx_valid/rx_ready RX FIFO head handshake;
//        rx_frame_err/rx_overrun/rx_parity_err one-cycle error pulses.
module uart_xcvr #(
    parameter int BAUDRATE_CNT  = 8,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int HALF      = BAUDRATE_CNT / 2;
    localparam int STOP_CLKS = STOP_BITS * BAUDRATE_CNT;
    localparam int CW        = $clog2(STOP_CLKS + 1);
    localparam int BW        = $clog2(DATA_BITS);
    localparam int AW        = $clog2(RX_FIFO_DEPTH);
    localparam logic PODD    = 1'(PARITY_ODD);

    // S_BRK is the tail of STOP after a low stop sample: wait for the line to go high.
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

    // ---------------- RX ----------------
    logic                 rx_meta_q, rxs_q;
    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_par_err_q, rx_par_err_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_push, par_bad;

    logic [DATA_BITS-1:0] fifo_mem_q [RX_FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 fifo_full, pop, push_ok;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        case (rx_state_q)
            S_IDLE: if (!rxs_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = CW'(HALF - 1);
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = rxs_q ? S_IDLE : S_DATA;
                    rx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                    rx_bit_d   = '0;
                    rx_par_d   = 1'b0;
                end else rx_cnt_d = rx_cnt_q - CW'(1);
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_par_d   = rx_par_q ^ rxs_q;
                    rx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                    if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = (P == 1) ? S_PARITY : S_STOP;
                    else rx_bit_d = rx_bit_q + BW'(1);
                end else rx_cnt_d = rx_cnt_q - CW'(1);
            end
            S_PARITY: begin
                if (rx_cnt_q == '0) begin
                    rx_par_d   = rx_par_q ^ rxs_q;
                    rx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                    rx_state_d = S_STOP;
                end else rx_cnt_d = rx_cnt_q - CW'(1);
            end
            S_STOP: begin
                if (rx_cnt_q == '0) rx_state_d = rxs_q ? S_IDLE : S_BRK;
                else rx_cnt_d = rx_cnt_q - CW'(1);
            end
            S_BRK: if (rxs_q) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // rx_par_q holds XOR of data and parity bits; it must equal the parity sense.
    assign par_bad = (P == 1) && (rx_par_q != PODD);

    always_comb begin
        rx_push        = 1'b0;
        rx_frame_err_d = 1'b0;
        rx_par_err_d   = 1'b0;
        if (rx_state_q == S_STOP && rx_cnt_q == '0) begin
            if (!rxs_q)      rx_frame_err_d = 1'b1;
            else if (par_bad) rx_par_err_d  = 1'b1;
            else             rx_push        = 1'b1;
        end
    end

    assign rx_valid  = (wptr_q != rptr_q);
    assign rx_data   = fifo_mem_q[rptr_q[AW-1:0]];
    assign fifo_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop       = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push writes into.
    assign push_ok      = rx_push && (!fifo_full || pop);
    assign rx_overrun_d = rx_push && fifo_full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)     rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q      <= 1'b1;
            rxs_q          <= 1'b1;
            rx_state_q     <= S_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_par_q       <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_par_err_q   <= 1'b0;
            rx_overrun_q   <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            rx_meta_q      <= uart_rx;
            rxs_q          <= rx_meta_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_par_q       <= rx_par_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_par_err_q   <= rx_par_err_d;
            rx_overrun_q   <= rx_overrun_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            if (push_ok) fifo_mem_q[wptr_q[AW-1:0]] <= rx_shift_q;
        end
    end

    assign rx_frame_err  = rx_frame_err_q;
    assign rx_overrun    = rx_overrun_q;
    assign rx_parity_err = rx_par_err_q;

    // ---------------- TX ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 uart_tx_q, uart_tx_d;
    logic                 tx_ready_q, tx_ready_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            S_IDLE: if (tx_valid && tx_ready_q) begin
                tx_shift_d = tx_data;
                tx_par_d   = (^tx_data) ^ PODD;
                tx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                tx_state_d = S_START;
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                    tx_bit_d   = '0;
                end else tx_cnt_d = tx_cnt_q - CW'(1);
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        tx_state_d = (P == 1) ? S_PARITY : S_STOP;
                        tx_cnt_d   = (P == 1) ? CW'(BAUDRATE_CNT - 1) : CW'(STOP_CLKS - 1);
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_cnt_d   = CW'(BAUDRATE_CNT - 1);
                    end
                end else tx_cnt_d = tx_cnt_q - CW'(1);
            end
            S_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = CW'(STOP_CLKS - 1);
                end else tx_cnt_d = tx_cnt_q - CW'(1);
            end
            S_STOP: begin
                if (tx_cnt_q == '0) tx_state_d = S_IDLE;
                else tx_cnt_d = tx_cnt_q - CW'(1);
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the pin is glitch-free
    // and the start bit appears the cycle after acceptance.
    always_comb begin
        case (tx_state_d)
            S_START:  uart_tx_d = 1'b0;
            S_DATA:   uart_tx_d = tx_shift_d[0];
            S_PARITY: uart_tx_d = tx_par_d;
            default:  uart_tx_d = 1'b1;
        endcase
        tx_ready_d = (tx_state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            uart_tx_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            uart_tx_q  <= uart_tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_ready = tx_ready_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - scoreboard testbench for uart_xcvr
module tb_uart_xcvr;
    localparam int BAUD = 8;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int ODD  = 0;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME  = (1 + DB + P + SB) * BAUD;
    localparam int BUDGET = 4000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loop_en = 1'b0;
    logic          rx_drv = 1'b1;
    logic          uart_rx, uart_tx;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          rx_frame_err, rx_overrun, rx_parity_err;

    int total = 0;
    int bad   = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    int n_pe  = 0;
    logic [DB-1:0] exp_q[$];

    always #5 clk = ~clk;
    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_xcvr #(
        .BAUDRATE_CNT(BAUD), .DATA_BITS(DB), .STOP_BITS(SB),
        .RX_FIFO_DEPTH(4), .PARITY_ODD(ODD)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .rx_parity_err(rx_parity_err)
    );

    always @(negedge clk) begin
        if (rx_frame_err)  n_fe <= n_fe + 1;
        if (rx_overrun)    n_ov <= n_ov + 1;
        if (rx_parity_err) n_pe <= n_pe + 1;
    end

    // Line level for bit period k of a frame carrying d (start, data LSB first, parity, stop).
    function automatic logic exp_bit(input logic [DB-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (P == 1 && k == DB + 1) return (^d) ^ 1'(ODD);
        return 1'b1;
    endfunction

    task automatic tx_send(input logic [DB-1:0] d);
        int c = 0;
        @(negedge clk);
        while (!tx_ready && c < FRAME * 4) begin @(negedge clk); c++; end
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL tx_ready_wait: got %b want 1", tx_ready); end
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = '0;
        if (loop_en) exp_q.push_back(d);
    endtask

    // Called on the first negedge after acceptance.
    task automatic check_frame(input logic [DB-1:0] d);
        for (int k = 0; k < FRAME; k++) begin
            total++;
            if ({tx_ready, uart_tx} !== {1'b0, exp_bit(d, k / BAUD)}) begin
                bad++;
                $display("FAIL tx_wave clk %0d: got ready,tx=%b%b want 0%b", k, tx_ready, uart_tx, exp_bit(d, k / BAUD));
            end
            @(negedge clk);
        end
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL tx_ready_end: got %b want 1", tx_ready); end
    endtask

    task automatic inject(input logic [DB-1:0] d, input logic stop, input logic par_flip);
        logic b;
        for (int k = 0; k <= 1 + DB + P; k++) begin
            b = exp_bit(d, k);
            if (k == 1 + DB + P) b = stop;
            if (P == 1 && k == DB + 1) b = b ^ par_flip;
            rx_drv = b;
            repeat (BAUD) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic drain(input int n);
        logic [DB-1:0] e;
        int c;
        rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            c = 0;
            while (!rx_valid && c < BUDGET) begin @(negedge clk); c++; end
            total++;
            if (!rx_valid) begin
                bad++; $display("FAIL rx_timeout: got rx_valid=0 want 1");
            end else if (exp_q.size() == 0) begin
                bad++; $display("FAIL rx_unexpected: got %h want none", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin bad++; $display("FAIL rx_data: got %h want %h", rx_data, e); end
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (uart_tx !== 1'b1)  begin bad++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== '0)    begin bad++; $display("FAIL rst_rx_data: got %h want 0", rx_data); end
        total++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000)
            begin bad++; $display("FAIL rst_err: got %b want 000", {rx_frame_err, rx_overrun, rx_parity_err}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback;
        int fe0 = n_fe, ov0 = n_ov, pe0 = n_pe;
        loop_en = 1'b1;
        tx_send(8'hA5);
        check_frame(8'hA5);
        drain(1);
        loop_en = 1'b0;
        total++; if (n_fe != fe0 || n_ov != ov0 || n_pe != pe0)
            begin bad++; $display("FAIL loop_err: got fe/ov/pe=%0d/%0d/%0d want %0d/%0d/%0d", n_fe, n_ov, n_pe, fe0, ov0, pe0); end
    endtask

    task automatic test_glitch;
        int fe0 = n_fe, pe0 = n_pe;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4 * BAUD) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        total++; if (n_fe != fe0 || n_pe != pe0)
            begin bad++; $display("FAIL glitch_err: got fe=%0d pe=%0d want %0d %0d", n_fe, n_pe, fe0, pe0); end
        exp_q.push_back(8'h5A);
        inject(8'h5A, 1'b1, 1'b0);
        drain(1);
    endtask

    task automatic test_framing;
        int fe0 = n_fe;
        inject(8'h3C, 1'b0, 1'b0);
        total++; if (n_fe != fe0 + 1) begin bad++; $display("FAIL frame_err_cnt: got %0d want %0d", n_fe - fe0, 1); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL frame_valid: got %b want 0", rx_valid); end
        exp_q.push_back(8'h3C);
        inject(8'h3C, 1'b1, 1'b0);
        drain(1);
    endtask

    task automatic test_overrun;
        int ov0 = n_ov;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            inject(8'(i), 1'b1, 1'b0);
        end
        total++; if (n_ov != ov0) begin bad++; $display("FAIL overrun_early: got %0d want 0", n_ov - ov0); end
        inject(8'h05, 1'b1, 1'b0);
        total++; if (n_ov != ov0 + 1) begin bad++; $display("FAIL overrun_cnt: got %0d want 1", n_ov - ov0); end
        drain(4);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL overrun_extra: got rx_valid=%b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        loop_en = 1'b1;
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'h81);
        drain(3);
        loop_en = 1'b0;
    endtask

    task automatic test_reset_midframe;
        loop_en = 1'b0;
        tx_send(8'hA5);
        repeat (4 * BAUD + 3) @(negedge clk);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b want 0", uart_tx); end
        rst = 1'b1;
        #1;
        total++; if (uart_tx !== 1'b1)  begin bad++; $display("FAIL mid_rst_tx: got %b want 1", uart_tx); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", tx_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        loop_en = 1'b1;
        tx_send(8'h3C);
        check_frame(8'h3C);
        drain(1);
        loop_en = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        int pe0;
        loop_en = 1'b1;
        tx_send(8'h07);
        check_frame(8'h07);
        drain(1);
        loop_en = 1'b0;
        pe0 = n_pe;
        inject(8'h07, 1'b1, 1'b1);
        total++; if (n_pe != pe0 + 1) begin bad++; $display("FAIL parity_err_cnt: got %0d want 1", n_pe - pe0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL parity_push: got rx_valid=%b want 0", rx_valid); end
    endtask
`endif

    initial begin
        test_reset;
        test_loopback;
        test_glitch;
        test_framing;
        test_overrun;
        test_back_to_back;
        test_reset_midframe;
`ifdef UART_PARITY_EN
        test_parity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
Parametrised full-duplex UART transceiver. It is the successor to the fixed 8N1 uart block and adds configurable data width, stop bits and clocks-per-bit. It also adds a start-bit glitch filter, framing and overrun detection, an RX FIFO, and valid/ready handshakes on both directions. It sits between the board pins (uart_rx/uart_tx) and the user logic (LED/key demos, command parsers).

Parameters:
BAUDRATE_CNT, 8, clocks per UART bit; must be even and ≥4.
DATA_BITS, 8, data bits per frame, range 5..9, sent/received LSB first.
STOP_BITS, 1, number of TX stop bits, 1 or 2; RX checks only the first stop bit.
RX_FIFO_DEPTH, 4, RX FIFO entries; must be a power of 2 and ≥2.
PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
uart_rx  in  1  serial input, asynchronous to clk, idles high
uart_tx  out  1  serial output, idles high
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  transmitter can accept a byte
rx_data  out  DATA_BITS  head of the RX FIFO
rx_valid  out  1  RX FIFO is not empty
rx_ready  in  1  consumer pops the FIFO head
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full
rx_parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without the macro)

Behaviour:
- Reset (asynchronous, active-high): uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, FIFO empty, both FSMs in IDLE, synchronizer flops =1. Asserting rst mid-frame aborts the frame immediately and uart_tx returns to 1 in the same instant.
- P = 1 if UART_PARITY_EN is defined, else 0. Bit period = BAUDRATE_CNT clocks.
- RX synchronizer: two flops; all RX logic uses the synchronized signal rxs.
- RX FSM: IDLE→START→DATA→(PARITY)→STOP→IDLE.
  - IDLE: when rxs=0, go to START and load the counter.
  - START: at BAUDRATE_CNT/2 clocks after entry, sample rxs (mid-bit).
    - If rxs=1, treat it as a glitch: return to IDLE; no byte, no error.
  - From the start mid-point, take one sample every BAUDRATE_CNT clocks: DATA_BITS data samples (LSB first), then P parity sample, then one stop sample.
  - Stop sample = 1:
    - If a parity error occurred: pulse rx_parity_err and discard the byte.
    - Otherwise push the byte; rx_valid/rx_data update the next cycle.
  - Stop sample = 0: pulse rx_frame_err, discard the byte, and stay in STOP until rxs=1 before entering IDLE (break condition).
- RX FIFO:
  - Pop when rx_valid & rx_ready.
  - Push with FIFO full and no pop in the same cycle: drop the new byte, pulse rx_overrun, keep FIFO contents.
  - Push and pop in the same cycle when full: both happen; no overrun.
  - Push into an empty FIFO: rx_valid=1 the following cycle.
  - Pointers are log2(RX_FIFO_DEPTH) bits wide with an extra wrap bit and wrap naturally.
- TX FSM: IDLE→START→DATA→(PARITY)→STOP→IDLE.
  - Accept on tx_valid & tx_ready; tx_data is latched and tx_ready=0 from the next cycle.
  - uart_tx=0 (start bit) from the cycle after acceptance.
  - Each bit is held for exactly BAUDRATE_CNT clocks: data LSB first, then P parity bit, then STOP_BITS×BAUDRATE_CNT clocks high.
  - tx_ready returns to 1 on the cycle after the last stop clock. Frame length is exactly (1+DATA_BITS+P+STOP_BITS)×BAUDRATE_CNT clocks.
  - tx_data/tx_valid changes during a frame are ignored.
- RX and TX are fully independent; simultaneous activity has no interaction.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a parity bit follows the data bits on both RX and TX. Even parity when PARITY_ODD=0, odd when PARITY_ODD=1. rx_parity_err is active and a mismatched byte is discarded.
- Undefined: no parity bit, frames are DATA_BITS+N+STOP_BITS, PARITY_ODD is ignored, and rx_parity_err is constant 0.

Test Plan:
- Loopback (uart_tx→uart_rx), defaults, no macro: send 0xA5 → uart_tx low for 8 clk, then bits 1,0,1,0,0,1,0,1 at 8 clk each, then 8 clk high; tx_ready low for exactly 80 clk. rx_valid=1 with rx_data=0xA5, no error pulses.
- Glitch: drive uart_rx low for 3 clk in idle → no rx_valid, no error pulse, RX FSM back in IDLE.
- Framing: inject 0x3C with a stop bit of 0 → one rx_frame_err pulse, FIFO stays empty. Then drive the line high and send 0x3C → rx_data=0x3C.
- Overrun: rx_ready=0, inject 5 bytes 0x01..0x05 → rx_overrun pulses once on byte 5. Draining gives 0x01..0x04 only.
- Parity (UART_PARITY_EN, PARITY_ODD=0): send 0x07 → parity bit 1, frame 88 clk. Inject 0x07 with parity bit 0 → rx_parity_err pulse, no push.
- Reset mid-frame: assert rst during TX data bit 3 → uart_tx=1 and tx_ready=1 immediately. After release, the next byte transmits correctly.
